// File: rtl/button_event_decoder_if.sv
// Signal bundle between the debouncer-side logic and the gesture decoder.
// The master drives the debounced level and consumes the gesture pulses;
// the slave is the decoder itself.
interface button_event_decoder_if;
  logic level_i;         // debounced button level, 1 = pressed
  logic short_press_o;   // one-cycle pulse: single short press
  logic long_press_o;    // one-cycle pulse: press held past the long threshold
  logic double_press_o;  // one-cycle pulse: second press released
  logic busy_o;          // decoder is in the middle of a gesture

  modport master (
    output level_i,
    input  short_press_o,
    input  long_press_o,
    input  double_press_o,
    input  busy_o
  );

  modport slave (
    input  level_i,
    output short_press_o,
    output long_press_o,
    output double_press_o,
    output busy_o
  );
endinterface

// File: rtl/button_event_decoder.sv
// Gesture decoder for a debounced push-button. Classifies each interaction
// as a short, long or double press and emits one registered pulse per
// gesture. Level edges always win over a timer expiring on the same edge.
module button_event_decoder #(
  parameter int unsigned ClkFreq     = 100_000_000,
  parameter int unsigned LongPressMs = 1000,
  parameter int unsigned DoubleGapMs = 250
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  button_event_decoder_if.slave       bus
);

  // Cycle counts are formed in 64 bits so large clocks/times cannot overflow.
  localparam logic [63:0] LongCycles = 64'(ClkFreq / 1000) * 64'(LongPressMs);
  localparam logic [63:0] GapCycles  = 64'(ClkFreq / 1000) * 64'(DoubleGapMs);
  localparam logic [63:0] MaxCycles  = (LongCycles > GapCycles) ? LongCycles : GapCycles;
  localparam int          TimerW     = $clog2(MaxCycles + 64'd1);

  localparam logic [TimerW-1:0] LongLast = TimerW'(LongCycles - 64'd1);
  localparam logic [TimerW-1:0] GapLast  = TimerW'(GapCycles - 64'd1);
  localparam logic [TimerW-1:0] TimerOne = TimerW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    HOLD,
    WAIT_GAP,
    PRESS2
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q;
  logic              prev_q;
  logic              rise, fall;
  logic              short_d, long_d, double_d;
  logic              short_q, long_q, double_q, busy_q;

  assign rise = bus.level_i & ~prev_q;
  assign fall = ~bus.level_i & prev_q;

  // Next-state and pulse decode; level events are tested before timer expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT_GAP;
        end else if (timer_q == LongLast) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall) state_d = IDLE;
      end
      WAIT_GAP: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (timer_q == GapLast) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timer, edge history and registered outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: reset clears every flop, outputs included, so an interrupted gesture leaves no pulse behind.
    if (rst_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      prev_q   <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      prev_q   <= bus.level_i;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= (state_d != IDLE);
      // Timer restarts on any state change and saturates instead of wrapping.
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + TimerOne;
      end
    end
  end

  assign bus.short_press_o  = short_q;
  assign bus.long_press_o   = long_q;
  assign bus.double_press_o = double_q;
  assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and randomized checks of the gesture decoder with
// ClkFreq=10_000, LongPressMs=5, DoubleGapMs=3 (50 / 30 cycle thresholds).
module tb_button_event_decoder;

  localparam int Long = 50;
  localparam int Gap  = 30;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .ClkFreq    (10_000),
    .LongPressMs(5),
    .DoubleGapMs(3)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse bookkeeping: edge index after which each pulse/busy change was seen.
  int edge_n = 0;
  int short_cnt, long_cnt, double_cnt;
  int short_at, long_at, double_at;
  int busy_rise_at, busy_fall_at;
  int viol = 0;
  logic prev_short = 1'b0, prev_long = 1'b0, prev_double = 1'b0, prev_busy = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_counts();
    short_cnt = 0; long_cnt = 0; double_cnt = 0;
    short_at = -1; long_at = -1; double_at = -1;
    busy_rise_at = -1; busy_fall_at = -1;
  endtask

  // Drive one level value into the next rising edge, then observe outputs.
  task automatic tick(input logic lvl);
    bus.level_i = lvl;
    @(posedge clk_i);
    edge_n++;
    #1;
    if (bus.short_press_o)  begin short_cnt++;  short_at  = edge_n; end
    if (bus.long_press_o)   begin long_cnt++;   long_at   = edge_n; end
    if (bus.double_press_o) begin double_cnt++; double_at = edge_n; end
    if ((int'(bus.short_press_o) + int'(bus.long_press_o) + int'(bus.double_press_o)) > 1) viol++;
    if ((bus.short_press_o && prev_short) || (bus.long_press_o && prev_long) ||
        (bus.double_press_o && prev_double)) viol++;
    if (!prev_busy && bus.busy_o) busy_rise_at = edge_n;
    if (prev_busy && !bus.busy_o) busy_fall_at = edge_n;
    prev_short  = bus.short_press_o;
    prev_long   = bus.long_press_o;
    prev_double = bus.double_press_o;
    prev_busy   = bus.busy_o;
  endtask

  task automatic run(input logic lvl, input int n);
    repeat (n) tick(lvl);
  endtask

  task automatic rst_tick(input logic lvl);
    rst_i = 1'b1;
    tick(lvl);
    rst_i = 1'b0;
  endtask

  function automatic int outs();
    return int'({bus.busy_o, bus.long_press_o, bus.short_press_o, bus.double_press_o});
  endfunction

  initial begin
    int e, f, f2;
    int m_short, m_long, m_double, p, g;
    logic second;

    bus.level_i = 1'b0;
    clear_counts();
    run(0, 2);
    rst_i = 1'b0;
    check("reset_outputs", outs(), 0);

    // Short press: 20 high, release, 40 idle.
    clear_counts();
    run(0, 3);
    e = edge_n + 1;
    run(1, 20);
    f = edge_n + 1;
    run(0, 40);
    check("s1_busy_rise", busy_rise_at, e);
    check("s1_short_cnt", short_cnt, 1);
    check("s1_short_at", short_at, f + Gap);
    check("s1_busy_fall", busy_fall_at, f + Gap);
    check("s1_other_pulses", long_cnt + double_cnt, 0);

    // Long press: hold 80 cycles.
    clear_counts();
    e = edge_n + 1;
    run(1, 80);
    f = edge_n + 1;
    run(0, 40);
    check("s2_long_cnt", long_cnt, 1);
    check("s2_long_at", long_at, e + Long);
    check("s2_other_pulses", short_cnt + double_cnt, 0);
    check("s2_busy_fall", busy_fall_at, f);

    // Double press: 10 / 15 / 10.
    clear_counts();
    run(1, 10);
    run(0, 15);
    run(1, 10);
    f2 = edge_n + 1;
    run(0, 40);
    check("s3_double_cnt", double_cnt, 1);
    check("s3_double_at", double_at, f2);
    check("s3_other_pulses", short_cnt + long_cnt, 0);

    // Release exactly on the long-expiry edge: fall wins.
    clear_counts();
    e = edge_n + 1;
    run(1, Long);
    f = edge_n + 1;
    run(0, 40);
    check("bA_long_cnt", long_cnt, 0);
    check("bA_short_cnt", short_cnt, 1);
    check("bA_short_at", short_at, e + Long + Gap);

    // Second rise exactly on the gap-expiry edge: rise wins.
    clear_counts();
    run(1, 10);
    run(0, Gap);
    run(1, 10);
    f2 = edge_n + 1;
    run(0, 40);
    check("bB_short_cnt", short_cnt, 0);
    check("bB_double_cnt", double_cnt, 1);
    check("bB_double_at", double_at, f2);

    // Reset in PRESS1.
    clear_counts();
    run(1, 5);
    rst_tick(0);
    check("r_press1_outs", outs(), 0);
    run(0, 80);
    check("r_press1_pulses", short_cnt + long_cnt + double_cnt, 0);

    // Reset in WAIT_GAP.
    clear_counts();
    run(1, 10);
    run(0, 10);
    rst_tick(0);
    check("r_gap_outs", outs(), 0);
    run(0, 80);
    check("r_gap_pulses", short_cnt + long_cnt + double_cnt, 0);

    // Reset in HOLD (the long pulse was already issued before reset).
    clear_counts();
    run(1, 60);
    rst_tick(0);
    check("r_hold_outs", outs(), 0);
    run(0, 80);
    check("r_hold_long", long_cnt, 1);
    check("r_hold_others", short_cnt + double_cnt, 0);

    // Normal short press after the resets.
    clear_counts();
    run(1, 20);
    f = edge_n + 1;
    run(0, 40);
    check("r_after_short_cnt", short_cnt, 1);
    check("r_after_short_at", short_at, f + Gap);

    // Level already high on the first edge after reset counts as a rise.
    rst_tick(1);
    check("first_edge_rst_outs", outs(), 0);
    tick(1);
    check("first_edge_busy", int'(bus.busy_o), 1);
    rst_tick(0);
    run(0, 5);

    // Random stream against a gesture-level model.
    clear_counts();
    m_short = 0; m_long = 0; m_double = 0;
    second = 1'b0;
    for (int i = 0; i < 60; i++) begin
      p = $urandom_range(1, 100);
      g = $urandom_range(1, 100);
      run(1, p);
      run(0, g);
      if (second) begin
        m_double++;
        second = 1'b0;
      end else if (p > Long) begin
        m_long++;
      end else if (g <= Gap) begin
        second = 1'b1;
      end else begin
        m_short++;
      end
    end
    if (second) m_short++;
    run(0, 100);
    check("rnd_short_cnt", short_cnt, m_short);
    check("rnd_long_cnt", long_cnt, m_long);
    check("rnd_double_cnt", double_cnt, m_double);
    check("pulse_exclusive_single", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
